// File: rtl/tx_mem_control.sv
// Frame buffer for the Ethernet video transmit path. A test-pattern generator fills the buffer.
// The serialiser reads it back, and a frame lock freezes the buffer while a full frame is sent.
module tx_mem_control #(
  parameter int SEGMENT_NUMBER_MAX = 720,
  parameter int SEGMENT_BYTES      = 1280,
  parameter int PAYLOAD_START      = 46
) (
  input  logic        clk125MHz,
  input  logic        rst,
  input  logic        ena,
  input  logic [7:0]  txid,
  input  logic [15:0] segment_num,
  input  logic [7:0]  redundancy,
  input  logic [11:0] byte_data_counter,
  input  logic        data_user,
  input  logic [23:0] startaddr,
  output logic [23:0] bramaddr24b,
  output logic [7:0]  doutb,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b
);

  localparam int          DEPTH       = SEGMENT_NUMBER_MAX * SEGMENT_BYTES;
  localparam int          AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [23:0] LAST_ADDR   = 24'(DEPTH - 1);
  localparam logic [23:0] DEPTH_24    = 24'(DEPTH);
  localparam logic [15:0] LAST_SEG    = 16'(SEGMENT_NUMBER_MAX - 1);
  localparam logic [23:0] PAYLOAD_OFS = 24'(PAYLOAD_START);

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_e;

  logic [7:0]  r_mem [DEPTH];
  logic [23:0] r_wraddr;
  phase_e      r_phase;
  logic [21:0] r_pix;
  logic [7:0]  r_frame_cnt;
  logic        r_lock;
  logic        r_du_d;

  logic [7:0]  w_eff_red;
  logic        w_lock_set;
  logic        w_lock_clr;
  logic        w_we;
  logic        w_at_end;
  logic [7:0]  w_wr_byte;
  logic [23:0] w_wraddr_next;
  phase_e      w_phase_next;
  logic [21:0] w_pix_next;
  logic [7:0]  w_frame_next;
  logic [23:0] w_rd_addr;

  // The lock closes at the first payload byte of the first copy of segment 0.
  // It opens when the last copy of the last segment leaves its payload section.
  assign w_eff_red  = (redundancy == 8'd0) ? 8'd1 : redundancy;
  assign w_lock_set = data_user && (segment_num == 16'd0) && (txid == 8'd0);
  assign w_lock_clr = r_du_d && !data_user && (segment_num == LAST_SEG)
                      && (txid >= (w_eff_red - 8'd1));

  assign w_we      = ena && !data_user && !r_lock && !w_lock_set;
  assign w_at_end  = (r_wraddr == LAST_ADDR);
  assign w_rd_addr = startaddr + {12'd0, byte_data_counter} - PAYLOAD_OFS;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can form.
  always_comb begin
    w_wr_byte     = rgb_r;
    w_wraddr_next = r_wraddr;
    w_phase_next  = r_phase;
    w_pix_next    = r_pix;
    w_frame_next  = r_frame_cnt;

    unique case (r_phase)
      PH_G:    w_wr_byte = r_pix[15:8];
      PH_B:    w_wr_byte = r_frame_cnt;
      default: w_wr_byte = r_pix[7:0];
    endcase

    if (w_we) begin
      if (w_at_end) begin
        w_wraddr_next = 24'd0;
        w_phase_next  = PH_R;
        w_pix_next    = 22'd0;
        w_frame_next  = r_frame_cnt + 8'd1;
      end else begin
        w_wraddr_next = r_wraddr + 24'd1;
        if (r_phase == PH_B) begin
          w_phase_next = PH_R;
          w_pix_next   = r_pix + 22'd1;
        end else begin
          w_phase_next = phase_e'(r_phase + 2'd1);
        end
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk125MHz or negedge rst) begin
    if (!rst) begin
      r_wraddr    <= 24'd0;
      r_phase     <= PH_R;
      r_pix       <= 22'd0;
      r_frame_cnt <= 8'd0;
      rgb_r       <= 8'd0;
      rgb_g       <= 8'd0;
      rgb_b       <= 8'd0;
    end else begin
      r_wraddr    <= w_wraddr_next;
      r_phase     <= w_phase_next;
      r_pix       <= w_pix_next;
      r_frame_cnt <= w_frame_next;
      rgb_r       <= w_pix_next[7:0];
      rgb_g       <= w_pix_next[15:8];
      rgb_b       <= w_frame_next;
    end
  end

  always_ff @(posedge clk125MHz or negedge rst) begin
    if (!rst) begin
      r_lock <= 1'b0;
      r_du_d <= 1'b0;
    end else begin
      r_du_d <= data_user;
      if (w_lock_set) begin
        r_lock <= 1'b1;
      end else if (w_lock_clr) begin
        r_lock <= 1'b0;
      end
    end
  end

  // NOTE: the buffer array has no reset. Its contents are don't-care until written,
  // and leaving it unreset keeps it mappable to block RAM.
  always_ff @(posedge clk125MHz) begin
    if (w_we) begin
      r_mem[r_wraddr[AW-1:0]] <= w_wr_byte;
    end
  end

  // Read data is registered from the previous cycle's address. Addresses past the end read as zero.
  always_ff @(posedge clk125MHz or negedge rst) begin
    if (!rst) begin
      bramaddr24b <= 24'd0;
      doutb       <= 8'd0;
    end else begin
      if (data_user) begin
        bramaddr24b <= w_rd_addr;
      end
      doutb <= (bramaddr24b < DEPTH_24) ? r_mem[bramaddr24b[AW-1:0]] : 8'd0;
    end
  end

endmodule

// File: tb/tb_tx_mem_control.sv
// Directed bench for tx_mem_control: reset, full-buffer fill, readback, bounds, frame lock
// and reset in the middle of a transmission, using 5 segments of 1280 bytes.
module tb_tx_mem_control;

  localparam int SEG_MAX   = 5;
  localparam int SEG_BYTES = 1280;
  localparam int PSTART    = 46;
  localparam int DEPTH     = SEG_MAX * SEG_BYTES;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  txid;
  logic [15:0] segment_num;
  logic [7:0]  redundancy;
  logic [11:0] byte_data_counter;
  logic        data_user;
  logic [23:0] startaddr;
  logic [23:0] bramaddr24b;
  logic [7:0]  doutb;
  logic [7:0]  rgb_r;
  logic [7:0]  rgb_g;
  logic [7:0]  rgb_b;

  int checks = 0;
  int errors = 0;

  always #4 clk = ~clk;

  tx_mem_control #(
    .SEGMENT_NUMBER_MAX(SEG_MAX),
    .SEGMENT_BYTES     (SEG_BYTES),
    .PAYLOAD_START     (PSTART)
  ) dut (
    .clk125MHz        (clk),
    .rst              (rst_n),
    .ena              (ena),
    .txid             (txid),
    .segment_num      (segment_num),
    .redundancy       (redundancy),
    .byte_data_counter(byte_data_counter),
    .data_user        (data_user),
    .startaddr        (startaddr),
    .bramaddr24b      (bramaddr24b),
    .doutb            (doutb),
    .rgb_r            (rgb_r),
    .rgb_g            (rgb_g),
    .rgb_b            (rgb_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First-frame contents: pixel k is stored as k[7:0], k[15:8], 0.
  function automatic logic [7:0] exp_fill(input int a);
    int k;
    k = a / 3;
    case (a % 3)
      0:       return k[7:0];
      1:       return k[15:8];
      default: return 8'h00;
    endcase
  endfunction

  // Single-byte read outside the lock: address after one edge, data after two.
  task automatic rd(input string tag, input logic [23:0] sa, input logic [11:0] bdc,
                    input logic [23:0] exp_addr, input logic [7:0] exp_data);
    segment_num       = 16'd1;
    txid              = 8'd0;
    startaddr         = sa;
    byte_data_counter = bdc;
    data_user         = 1'b1;
    step();
    check({tag, "_addr"}, 32'(bramaddr24b), 32'(exp_addr));
    step();
    check({tag, "_data"}, 32'(doutb), 32'(exp_data));
    data_user = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] old_bytes [6];

    rst_n = 1'b0; ena = 1'b1; txid = 8'd0; segment_num = 16'd0; redundancy = 8'd1;
    byte_data_counter = 12'd0; data_user = 1'b0; startaddr = 24'd0;

    // Reset held with ena=1: all outputs stay zero.
    repeat (4) step();
    check("rst_addr", 32'(bramaddr24b), 32'd0);
    check("rst_dout", 32'(doutb), 32'd0);
    check("rst_r", 32'(rgb_r), 32'd0);
    check("rst_g", 32'(rgb_g), 32'd0);
    check("rst_b", 32'(rgb_b), 32'd0);

    // Fill the whole buffer once.
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      if (i == 2) check("fill_r_at2", 32'(rgb_r), 32'd0);
      if (i == 3) check("fill_r_at3", 32'(rgb_r), 32'd1);
      if (i == DEPTH - 1) begin
        check("fill_end_r", 32'(rgb_r), 32'h55);
        check("fill_end_g", 32'(rgb_g), 32'h08);
        check("fill_end_b", 32'(rgb_b), 32'h00);
      end
    end
    ena = 1'b0;
    check("wrap_r", 32'(rgb_r), 32'd0);
    check("wrap_g", 32'(rgb_g), 32'd0);
    check("wrap_b", 32'(rgb_b), 32'd1);

    // Readback of segment 1.
    segment_num = 16'd1; startaddr = 24'd1280; data_user = 1'b1;
    for (int i = 0; i <= SEG_BYTES + 1; i++) begin
      if (i < SEG_BYTES) byte_data_counter = 12'(PSTART + i);
      step();
      if (i == SEG_BYTES - 1) check("rb_last_addr", 32'(bramaddr24b), 32'd2559);
      if (i >= 1 && i <= SEG_BYTES)
        check("rb_data", 32'(doutb), 32'(exp_fill(1280 + i - 1)));
    end
    data_user = 1'b0;
    byte_data_counter = 12'd0;
    repeat (3) step();
    check("rb_hold_addr", 32'(bramaddr24b), 32'd2559);

    // Bounds and address wrap.
    rd("oob", 24'd6400, 12'd46, 24'd6400, 8'h00);
    rd("last", 24'd6399, 12'd46, 24'd6399, 8'h55);
    rd("neg", 24'd0, 12'd45, 24'hFFFFFF, 8'h00);

    // Writes resume at address 0 with frame_cnt 1.
    ena = 1'b1;
    repeat (3) step();
    ena = 1'b0;
    check("resume_r", 32'(rgb_r), 32'd1);
    rd("f1_a2", 24'd2, 12'd46, 24'd2, 8'h01);
    rd("f1_a3", 24'd3, 12'd46, 24'd3, 8'h01);
    old_bytes[0] = 8'h00; old_bytes[1] = 8'h00; old_bytes[2] = 8'h01;
    old_bytes[3] = 8'h01; old_bytes[4] = 8'h00; old_bytes[5] = 8'h00;

    // Frame lock across 5 segments x 2 copies with ena held high.
    redundancy = 8'd2;
    for (int s = 0; s < SEG_MAX; s++) begin
      for (int t = 0; t < 2; t++) begin
        segment_num = 16'(s);
        txid        = 8'(t);
        ena         = 1'b1;
        data_user   = 1'b1;
        if (s == SEG_MAX - 1 && t == 1) begin
          startaddr = 24'd0;
          for (int j = 0; j < 6; j++) begin
            byte_data_counter = 12'(PSTART + j);
            step();
            if (j >= 1) check("lock_rd", 32'(doutb), 32'(old_bytes[j-1]));
          end
        end else begin
          startaddr = 24'(s * SEG_BYTES);
          for (int j = 0; j < 4; j++) begin
            byte_data_counter = 12'(PSTART + j);
            step();
          end
          data_user = 1'b0;
          repeat (4) step();
          check("lock_hold_r", 32'(rgb_r), 32'd1);
        end
      end
    end
    data_user = 1'b0;
    step();
    check("lock_fall_rd", 32'(doutb), 32'(old_bytes[5]));
    check("lock_fall_r", 32'(rgb_r), 32'd1);
    step();
    step();
    check("unlock_r2", 32'(rgb_r), 32'd1);
    step();
    ena = 1'b0;
    check("unlock_r3", 32'(rgb_r), 32'd2);
    rd("unlock_a5", 24'd5, 12'd46, 24'd5, 8'h01);
    rd("unlock_a3", 24'd3, 12'd46, 24'd3, 8'h01);

    // Reset in the middle of segment 2 while the frame is locked.
    ena = 1'b1; txid = 8'd0;
    segment_num = 16'd0; startaddr = 24'd0; data_user = 1'b1;
    for (int j = 0; j < 4; j++) begin byte_data_counter = 12'(PSTART + j); step(); end
    data_user = 1'b0;
    repeat (2) step();
    segment_num = 16'd1; startaddr = 24'd1280; data_user = 1'b1;
    repeat (2) step();
    segment_num = 16'd2; startaddr = 24'd2560; data_user = 1'b1;
    repeat (2) step();
    check("seg2_addr", 32'(bramaddr24b), 32'(2560 + 3));
    rst_n = 1'b0;
    #1;
    check("mrst_addr", 32'(bramaddr24b), 32'd0);
    check("mrst_dout", 32'(doutb), 32'd0);
    check("mrst_r", 32'(rgb_r), 32'd0);
    step();
    rst_n = 1'b1; data_user = 1'b0;
    repeat (3) step();
    ena = 1'b0;
    check("mrst_resume_r", 32'(rgb_r), 32'd1);
    rd("mrst_a2", 24'd2, 12'd46, 24'd2, 8'h00);
    rd("mrst_a3", 24'd3, 12'd46, 24'd3, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
